regfile_write_buffer: RTL and testbench
=======================================

Name: regfile_write_buffer

Overview:
- Initiator-side companion to the 32x32 register file; owns its single write port (writeReg/writeEn/writeData).
- Queues writeback requests from the datapath in a small in-order FIFO and drains one entry per cycle when drainEn permits.
- Forwards pending (not yet written) values to the two read ports, so read-after-write stays correct while entries are queued.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- DATA_W, 32: register data width.
- ADDR_W, 5: register address width.
- ZERO_DISCARD, 1: when 1, pushes to register 0 are accepted but not stored, and reads of register 0 never hit.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- resetN  in  1  synchronous active-low reset.
- inValid  in  1  writeback request valid.
- inReady  out  1  buffer can accept a request.
- inReg  in  ADDR_W  destination register of the request.
- inData  in  DATA_W  data of the request.
- drainEn  in  1  register-file write port is available this cycle.
- writeReg  out  ADDR_W  to register file; head entry address.
- writeData  out  DATA_W  to register file; head entry data.
- writeEn  out  1  to register file; a write happens this edge.
- rdReg1  in  ADDR_W  read-port-1 address (same value driven to readReg1).
- rdReg2  in  ADDR_W  read-port-2 address.
- fwdHit1  out  1  a pending entry matches rdReg1.
- fwdData1  out  DATA_W  data of the youngest matching entry for rdReg1.
- fwdHit2  out  1  a pending entry matches rdReg2.
- fwdData2  out  DATA_W  data of the youngest matching entry for rdReg2.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Storage: circular FIFO with head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a count register.
- Reset: with resetN low at a rising edge, pointers and count clear to 0 and all entry-valid bits clear. While resetN is low, inReady=0, writeEn=0, fwdHit1/2=0. After reset: count=0, empty=1, full=0, writeData and writeReg are don't-care but writeEn=0.
- Push: occurs when inValid && inReady. inReady = !full, with no combinational dependence on drainEn. With ZERO_DISCARD=1 and inReg==0, the handshake completes and nothing is stored (count unchanged).
- Drain:
  - writeEn = !empty && drainEn, combinational.
  - writeReg and writeData come from the head entry.
  - On the edge where writeEn=1, the head advances and the register file captures the data on that same edge.
  - Latency: minimum 1 cycle from push edge to appearing on the write port; in-order, no reordering or merging.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, push is refused even if a pop occurs that cycle.
- Forwarding:
  - Combinational compare of rdRegN against all valid entries.
  - Youngest (closest to tail) match wins.
  - The head entry being written this cycle still counts as a hit.
  - The incoming same-cycle push is NOT considered.
  - rdRegN==0 never hits when ZERO_DISCARD=1.
  - fwdDataN = 0 when fwdHitN = 0.
- Reset mid-operation: all queued entries are dropped without being written; the register-file contents are unaffected by this block.
- Illegal conditions: none. Pushes while full are ignored; drainEn while empty produces no write.

Test Plan:
1. Reset with resetN=0 for 2 cycles -> count=0, empty=1, writeEn=0, inReady=0 during reset, inReady=1 the cycle after.
2. drainEn=0; push (r3,0xA), (r7,0xB), (r3,0xC); then drainEn=1 -> writes r3=0xA, r7=0xB, r3=0xC on 3 consecutive edges, then empty=1, writeEn=0.
3. drainEn=0; push 4 entries -> full=1, inReady=0, and a 5th push is not stored. Then drainEn=1 with inValid held -> count stays 4 for one cycle (push refused), then alternates with a push+pop steady state; pointer wrap is verified by data order.
4. Queue (r5,0x11), (r5,0x22); rdReg1=5, rdReg2=6 -> fwdHit1=1, fwdData1=0x22, fwdHit2=0, fwdData2=0. After both drain -> fwdHit1=0.
5. Push (r0,0xFF) with ZERO_DISCARD=1 -> handshake completes, count stays 0, no write issued; rdReg1=0 -> fwdHit1=0.
6. Queue 3 entries, assert resetN=0 for one edge while drainEn=1 -> no writeEn during reset, count=0 afterwards, and no stale entries are written later.

Source files
------------

// File: rtl/regfile_write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_buffer_if
//  Brief    : Push, write-port, forwarding and status signals of the
//             register-file write buffer, with datapath/buffer modports.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_write_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic                inValid;
    logic                inReady;
    logic [ADDR_W-1:0]   inReg;
    logic [DATA_W-1:0]   inData;

    logic                drainEn;
    logic [ADDR_W-1:0]   writeReg;
    logic [DATA_W-1:0]   writeData;
    logic                writeEn;

    logic [ADDR_W-1:0]   rdReg1;
    logic [ADDR_W-1:0]   rdReg2;
    logic                fwdHit1;
    logic [DATA_W-1:0]   fwdData1;
    logic                fwdHit2;
    logic [DATA_W-1:0]   fwdData2;

    logic [c_CNT_W-1:0]  count;
    logic                empty;
    logic                full;

    // Datapath / register-file side.
    modport master (
        output inValid, inReg, inData, drainEn, rdReg1, rdReg2,
        input  inReady, writeReg, writeData, writeEn,
               fwdHit1, fwdData1, fwdHit2, fwdData2,
               count, empty, full
    );

    // Write-buffer side.
    modport slave (
        input  inValid, inReg, inData, drainEn, rdReg1, rdReg2,
        output inReady, writeReg, writeData, writeEn,
               fwdHit1, fwdData1, fwdHit2, fwdData2,
               count, empty, full
    );
endinterface

`default_nettype wire

// File: rtl/regfile_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_buffer
//  Brief    : In-order writeback FIFO owning the register-file write port,
//             with youngest-match forwarding of pending values to two reads.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_write_buffer #(
    parameter int DEPTH        = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                   CLK,
    input  logic                   resetN,
    regfile_write_buffer_if.slave  wb
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [ADDR_W-1:0]  r_reg  [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_in_ready;
    logic               w_push;
    logic               w_discard;
    logic               w_store;
    logic               w_pop;
    logic [DATA_W:0]    w_fwd1;
    logic [DATA_W:0]    w_fwd2;

    // ------------------------------------------------------------------
    // Handshake and drain decode. Everything visible is gated by resetN
    // so a reset landing mid-queue never leaks a write or a hit.
    // ------------------------------------------------------------------
    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_in_ready = resetN && !w_full;
    assign w_push     = wb.inValid && w_in_ready;
    assign w_discard  = (ZERO_DISCARD != 0) && (wb.inReg == '0);
    assign w_store    = w_push && !w_discard;
    assign w_pop      = resetN && !w_empty && wb.drainEn;

    // ------------------------------------------------------------------
    // Pointer, count and valid-bit state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!resetN) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // store and pop never target the same slot: that needs count==0
            if (w_store) begin
                r_tail          <= r_tail + c_PTR_ONE;
                r_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head          <= r_head + c_PTR_ONE;
                r_valid[r_head] <= 1'b0;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; r_valid qualifies every use.
    always_ff @(posedge CLK) begin
        if (w_store) begin
            r_reg[r_tail]  <= wb.inReg;
            r_data[r_tail] <= wb.inData;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: scan from head (oldest) toward tail so the last match
    // seen is the youngest one. The head being drained still counts.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] rd);
        logic [DATA_W:0]    res;
        logic [c_PTR_W-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + c_PTR_W'(i);
            if (r_valid[idx] && (r_reg[idx] == rd) &&
                !((ZERO_DISCARD != 0) && (rd == '0))) begin
                res = {1'b1, r_data[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        if (resetN) begin
            w_fwd1 = fwd_lookup(wb.rdReg1);
            w_fwd2 = fwd_lookup(wb.rdReg2);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb.inReady   = w_in_ready;
    assign wb.writeEn   = w_pop;
    assign wb.writeReg  = r_reg[r_head];
    assign wb.writeData = r_data[r_head];
    assign wb.fwdHit1   = w_fwd1[DATA_W];
    assign wb.fwdData1  = w_fwd1[DATA_W-1:0];
    assign wb.fwdHit2   = w_fwd2[DATA_W];
    assign wb.fwdData2  = w_fwd2[DATA_W-1:0];
    assign wb.count     = r_count;
    assign wb.empty     = w_empty;
    assign wb.full      = w_full;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_buffer
//  Brief    : Vector table plus write-port scoreboard for the write buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic CLK    = 1'b0;
    logic resetN = 1'b0;
    always #5 CLK = ~CLK;

    regfile_write_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    regfile_write_buffer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_DISCARD(1)
    ) dut (
        .CLK    (CLK),
        .resetN (resetN),
        .wb     (wb)
    );

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
        logic        dr;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        rdy;
        logic        we;
        logic [2:0]  cnt;
        logic        h1;
        logic [31:0] f1;
        logic        h2;
        logic [31:0] f2;
    } vec_t;

    vec_t        vecs[$];
    logic [36:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] r, input logic [31:0] d,
                                input logic dr, input logic [4:0] rd1, input logic [4:0] rd2,
                                input logic rdy, input logic we, input logic [2:0] cnt,
                                input logic h1, input logic [31:0] f1,
                                input logic h2, input logic [31:0] f2);
        vec_t t;
        t.v = v; t.r = r; t.d = d; t.dr = dr; t.rd1 = rd1; t.rd2 = rd2;
        t.rdy = rdy; t.we = we; t.cnt = cnt; t.h1 = h1; t.f1 = f1; t.h2 = h2; t.f2 = f2;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Pops the scoreboard for a write seen this cycle, then records an accepted push.
    task automatic sb_tick(input logic acc, input logic [4:0] r, input logic [31:0] d);
        logic [36:0] ent;
        if (wb.writeEn === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got r%0d=0x%0h, required no write",
                         wb.writeReg, wb.writeData);
            end else begin
                ent = sb_q.pop_front();
                if ({wb.writeReg, wb.writeData} !== ent) begin
                    errors++;
                    $display("FAIL write_order: got r%0d=0x%0h, required r%0d=0x%0h",
                             wb.writeReg, wb.writeData, ent[36:32], ent[31:0]);
                end
            end
        end
        if (acc && (r != 5'd0)) sb_q.push_back({r, d});
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge CLK);
        wb.inValid = t.v;
        wb.inReg   = t.r;
        wb.inData  = t.d;
        wb.drainEn = t.dr;
        wb.rdReg1  = t.rd1;
        wb.rdReg2  = t.rd2;
        #1;
        check($sformatf("inReady[%0d]", idx),  wb.inReady,  t.rdy);
        check($sformatf("writeEn[%0d]", idx),  wb.writeEn,  t.we);
        check($sformatf("count[%0d]", idx),    wb.count,    t.cnt);
        check($sformatf("empty[%0d]", idx),    wb.empty,    t.cnt == 3'd0);
        check($sformatf("full[%0d]", idx),     wb.full,     t.cnt == 3'd4);
        check($sformatf("fwdHit1[%0d]", idx),  wb.fwdHit1,  t.h1);
        check($sformatf("fwdData1[%0d]", idx), wb.fwdData1, t.f1);
        check($sformatf("fwdHit2[%0d]", idx),  wb.fwdHit2,  t.h2);
        check($sformatf("fwdData2[%0d]", idx), wb.fwdData2, t.f2);
        sb_tick(t.v && t.rdy, t.r, t.d);
    endtask

    initial begin
        //                 v  r   d       dr rd1 rd2 rdy we cnt h1 f1      h2 f2
        // in-order drain, same-cycle push invisible to forwarding
        vecs.push_back(mk(1, 3, 32'hA,   0, 0,  0,  1,  0, 0,  0, 0,      0, 0));
        vecs.push_back(mk(1, 7, 32'hB,   0, 0,  0,  1,  0, 1,  0, 0,      0, 0));
        vecs.push_back(mk(1, 3, 32'hC,   0, 3,  7,  1,  0, 2,  1, 32'hA,  1, 32'hB));
        vecs.push_back(mk(0, 0, 0,       1, 3,  7,  1,  1, 3,  1, 32'hC,  1, 32'hB));
        vecs.push_back(mk(0, 0, 0,       1, 3,  7,  1,  1, 2,  1, 32'hC,  1, 32'hB));
        vecs.push_back(mk(0, 0, 0,       1, 3,  7,  1,  1, 1,  1, 32'hC,  0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 3,  7,  1,  0, 0,  0, 0,      0, 0));
        // fill, refuse while full, push+pop steady state across the wrap
        vecs.push_back(mk(1, 1, 32'h101, 0, 0,  0,  1,  0, 0,  0, 0,      0, 0));
        vecs.push_back(mk(1, 2, 32'h102, 0, 0,  0,  1,  0, 1,  0, 0,      0, 0));
        vecs.push_back(mk(1, 3, 32'h103, 0, 0,  0,  1,  0, 2,  0, 0,      0, 0));
        vecs.push_back(mk(1, 4, 32'h104, 0, 0,  0,  1,  0, 3,  0, 0,      0, 0));
        vecs.push_back(mk(1, 5, 32'h105, 0, 0,  0,  0,  0, 4,  0, 0,      0, 0));
        vecs.push_back(mk(1, 5, 32'h105, 1, 5,  1,  0,  1, 4,  0, 0,      1, 32'h101));
        vecs.push_back(mk(1, 5, 32'h105, 1, 5,  1,  1,  1, 3,  0, 0,      0, 0));
        vecs.push_back(mk(1, 6, 32'h106, 1, 5,  1,  1,  1, 3,  1, 32'h105, 0, 0));
        vecs.push_back(mk(1, 7, 32'h107, 1, 5,  1,  1,  1, 3,  1, 32'h105, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 5,  1,  1,  1, 3,  1, 32'h105, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 5,  1,  1,  1, 2,  0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0,  0,  1,  1, 1,  0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,  0,  1,  0, 0,  0, 0,      0, 0));
        // youngest match wins
        vecs.push_back(mk(1, 5, 32'h11,  0, 5,  6,  1,  0, 0,  0, 0,      0, 0));
        vecs.push_back(mk(1, 5, 32'h22,  0, 5,  6,  1,  0, 1,  1, 32'h11, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 5,  6,  1,  0, 2,  1, 32'h22, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 5,  6,  1,  1, 2,  1, 32'h22, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 5,  6,  1,  1, 1,  1, 32'h22, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 5,  6,  1,  0, 0,  0, 0,      0, 0));
        // register 0 discarded
        vecs.push_back(mk(1, 0, 32'hFF,  1, 0,  0,  1,  0, 0,  0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0,  0,  1,  0, 0,  0, 0,      0, 0));
        // queue three entries ahead of a mid-operation reset
        vecs.push_back(mk(1, 9,  32'h901, 0, 9, 0,  1,  0, 0,  0, 0,      0, 0));
        vecs.push_back(mk(1, 10, 32'h902, 0, 9, 0,  1,  0, 1,  1, 32'h901, 0, 0));
        vecs.push_back(mk(1, 11, 32'h903, 0, 9, 0,  1,  0, 2,  1, 32'h901, 0, 0));

        // Reset held for two edges with live-looking inputs.
        wb.inValid = 1'b1; wb.inReg = 5'd3; wb.inData = 32'h55;
        wb.drainEn = 1'b1; wb.rdReg1 = 5'd3; wb.rdReg2 = 5'd0;
        resetN = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK); #1;
            check($sformatf("rst_inReady[%0d]", c), wb.inReady, 1'b0);
            check($sformatf("rst_writeEn[%0d]", c), wb.writeEn, 1'b0);
            check($sformatf("rst_fwdHit1[%0d]", c), wb.fwdHit1, 1'b0);
        end
        @(negedge CLK);
        resetN = 1'b1; wb.inValid = 1'b0; wb.drainEn = 1'b0;
        #1;
        check("post_rst_count",   wb.count,   3'd0);
        check("post_rst_empty",   wb.empty,   1'b1);
        check("post_rst_full",    wb.full,    1'b0);
        check("post_rst_inReady", wb.inReady, 1'b1);
        check("post_rst_writeEn", wb.writeEn, 1'b0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset while three entries are queued and the write port is open.
        @(negedge CLK);
        wb.inValid = 1'b0; wb.drainEn = 1'b1; wb.rdReg1 = 5'd9;
        resetN = 1'b0;
        #1;
        check("midrst_writeEn", wb.writeEn, 1'b0);
        check("midrst_inReady", wb.inReady, 1'b0);
        check("midrst_fwdHit1", wb.fwdHit1, 1'b0);
        @(negedge CLK);
        resetN = 1'b1;
        #1;
        check("midrst_count", wb.count,   3'd0);
        check("midrst_empty", wb.empty,   1'b1);
        check("midrst_fwd",   wb.fwdHit1, 1'b0);
        sb_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); #1;
            check($sformatf("stale_writeEn[%0d]", c), wb.writeEn, 1'b0);
            sb_tick(1'b0, 5'd0, 32'd0);
        end

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
